// File: rtl/mult_issue_ctrl_if.sv
// Signal bundle between the QR column scheduler, the multiply engine and the
// result consumer. The master view belongs to mult_issue_ctrl.
interface mult_issue_ctrl_if #(
  parameter int W = 16
);
  logic         i_load_valid;
  logic         o_load_ready;
  logic [W-1:0] i_a0;
  logic [W-1:0] i_a1;
  logic [W-1:0] i_a2;
  logic [W-1:0] i_b0;
  logic [W-1:0] i_b1;
  logic [W-1:0] i_b2;

  logic         o_start;
  logic [W-1:0] o_multiplier;
  logic [W-1:0] o_multiplicand;
  logic         i_stop;
  logic [W-1:0] i_q1;
  logic [W-1:0] i_q2;
  logic [W-1:0] i_q3;
  logic         o_eng_clr;

  logic         o_res_valid;
  logic         i_res_ready;
  logic [W-1:0] o_r0;
  logic [W-1:0] o_r1;
  logic [W-1:0] o_r2;
  logic         o_err;
  logic         o_busy;

  modport master (
    input  i_load_valid, i_a0, i_a1, i_a2, i_b0, i_b1, i_b2,
    input  i_stop, i_q1, i_q2, i_q3, i_res_ready,
    output o_load_ready, o_start, o_multiplier, o_multiplicand, o_eng_clr,
    output o_res_valid, o_r0, o_r1, o_r2, o_err, o_busy
  );

  modport slave (
    output i_load_valid, i_a0, i_a1, i_a2, i_b0, i_b1, i_b2,
    output i_stop, i_q1, i_q2, i_q3, i_res_ready,
    input  o_load_ready, o_start, o_multiplier, o_multiplicand, o_eng_clr,
    input  o_res_valid, o_r0, o_r1, o_r2, o_err, o_busy
  );
endinterface

// File: rtl/mult_issue_ctrl.sv
// Initiator for the three-product multiply engine: issues one job of three
// operand pairs, captures the products, and holds them under valid/ready.
module mult_issue_ctrl #(
  parameter int W       = 16,
  parameter int TIMEOUT = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  mult_issue_ctrl_if.master bus
);

  localparam int SW = $clog2(TIMEOUT + 1);

  localparam logic [SW-1:0] S_ONE        = SW'(1);
  localparam logic [SW-1:0] S_LAST_PAIR0 = SW'(1);
  localparam logic [SW-1:0] S_PAIR1      = SW'(2);
  localparam logic [SW-1:0] S_LAST_ISSUE = SW'(3);
  localparam logic [SW-1:0] S_TIMEOUT    = SW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CLEAR,
    ST_HOLD
  } state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  s_q, s_d;
  logic [W-1:0]   a_q [3];
  logic [W-1:0]   a_d [3];
  logic [W-1:0]   b_q [3];
  logic [W-1:0]   b_d [3];
  logic [W-1:0]   r_q [3];
  logic [W-1:0]   r_d [3];
  logic           err_q, err_d;
  logic           load_ready_q, load_ready_d;
  logic           start_q, start_d;
  logic           eng_clr_q, eng_clr_d;
  logic           res_valid_q, res_valid_d;
  logic           busy_q, busy_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [W-1:0]   mcand_q, mcand_d;

  logic [W-1:0]   ld_a [3];
  logic [W-1:0]   ld_b [3];
  logic [W-1:0]   q_in [3];

  assign ld_a[0] = bus.i_a0;
  assign ld_a[1] = bus.i_a1;
  assign ld_a[2] = bus.i_a2;
  assign ld_b[0] = bus.i_b0;
  assign ld_b[1] = bus.i_b1;
  assign ld_b[2] = bus.i_b2;
  assign q_in[0] = bus.i_q1;
  assign q_in[1] = bus.i_q2;
  assign q_in[2] = bus.i_q3;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      s_q          <= '0;
      err_q        <= 1'b0;
      load_ready_q <= 1'b1;
      start_q      <= 1'b0;
      eng_clr_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      mplier_q     <= '0;
      mcand_q      <= '0;
      for (int i = 0; i < 3; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        r_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      err_q        <= err_d;
      load_ready_q <= load_ready_d;
      start_q      <= start_d;
      eng_clr_q    <= eng_clr_d;
      res_valid_q  <= res_valid_d;
      busy_q       <= busy_d;
      mplier_q     <= mplier_d;
      mcand_q      <= mcand_d;
      for (int i = 0; i < 3; i++) begin
        a_q[i] <= a_d[i];
        b_q[i] <= b_d[i];
        r_q[i] <= r_d[i];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    a_d          = a_q;
    b_d          = b_q;
    r_d          = r_q;
    err_d        = err_q;
    mplier_d     = mplier_q;
    mcand_d      = mcand_q;
    load_ready_d = 1'b0;
    start_d      = 1'b0;
    eng_clr_d    = 1'b0;
    res_valid_d  = 1'b0;
    busy_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_load_valid) begin
          a_d     = ld_a;
          b_d     = ld_b;
          err_d   = 1'b0;
          s_d     = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        s_d = s_q + S_ONE;
        // A stop before the engine has seen all three pairs is a protocol error.
        if (bus.i_stop) begin
          err_d   = 1'b1;
          state_d = ST_CLEAR;
        end else if (s_q == S_LAST_ISSUE) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        s_d = s_q + S_ONE;
        if (bus.i_stop) begin
          r_d     = q_in;
          state_d = ST_CLEAR;
        end else if (s_q == S_TIMEOUT) begin
          err_d   = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_d = err_q ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.i_res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Operands are registered against the step the engine will be in next cycle.
    if (state_d == ST_ISSUE || state_d == ST_WAIT) begin
      if (s_d <= S_LAST_PAIR0) begin
        mplier_d = a_d[0];
        mcand_d  = b_d[0];
      end else if (s_d == S_PAIR1) begin
        mplier_d = a_d[1];
        mcand_d  = b_d[1];
      end else begin
        mplier_d = a_d[2];
        mcand_d  = b_d[2];
      end
    end

    load_ready_d = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    start_d      = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    eng_clr_d    = (state_d == ST_CLEAR);
    res_valid_d  = (state_d == ST_HOLD);
  end

  assign bus.o_load_ready   = load_ready_q;
  assign bus.o_start        = start_q;
  assign bus.o_multiplier   = mplier_q;
  assign bus.o_multiplicand = mcand_q;
  assign bus.o_eng_clr      = eng_clr_q;
  assign bus.o_res_valid    = res_valid_q;
  assign bus.o_r0           = r_q[0];
  assign bus.o_r1           = r_q[1];
  assign bus.o_r2           = r_q[2];
  assign bus.o_err          = err_q;
  assign bus.o_busy         = busy_q;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Randomized bench for mult_issue_ctrl: each job is predicted from its stop
// cycle alone (CLEAR cycle, abort flag, captured products) and checked per cycle.
module tb_mult_issue_ctrl;

  localparam int W       = 16;
  localparam int TIMEOUT = 8;
  localparam int NO_STOP = 99;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mult_issue_ctrl_if #(.W(W)) bus ();

  mult_issue_ctrl #(
    .W       (W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0][W-1:0] exp_r;
  logic              exp_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string ph, input logic lr, input logic busy,
                            input logic start, input logic clr, input logic valid,
                            input logic err);
    check_eq({ph, ".load_ready"}, bus.o_load_ready, lr);
    check_eq({ph, ".busy"},       bus.o_busy,       busy);
    check_eq({ph, ".start"},      bus.o_start,      start);
    check_eq({ph, ".eng_clr"},    bus.o_eng_clr,    clr);
    check_eq({ph, ".res_valid"},  bus.o_res_valid,  valid);
    check_eq({ph, ".err"},        bus.o_err,        err);
    check_eq({ph, ".r0"},         bus.o_r0,         exp_r[0]);
    check_eq({ph, ".r1"},         bus.o_r1,         exp_r[1]);
    check_eq({ph, ".r2"},         bus.o_r2,         exp_r[2]);
  endtask

  task automatic noise(input bit with_stop);
    bus.i_load_valid = 1'($urandom_range(0, 1));
    bus.i_a0 = W'($urandom); bus.i_a1 = W'($urandom); bus.i_a2 = W'($urandom);
    bus.i_b0 = W'($urandom); bus.i_b1 = W'($urandom); bus.i_b2 = W'($urandom);
    bus.i_res_ready = 1'($urandom_range(0, 1));
    bus.i_q1 = W'($urandom); bus.i_q2 = W'($urandom); bus.i_q3 = W'($urandom);
    if (with_stop) bus.i_stop = 1'($urandom_range(0, 1));
  endtask

  function automatic int pair_of(input int e);
    if (e <= 1) return 0;
    if (e == 2) return 1;
    return 2;
  endfunction

  // Entered and left in an IDLE cycle, just after the sampling point.
  task automatic do_job(input logic [2:0][W-1:0] a, input logic [2:0][W-1:0] b,
                        input int stop_at, input int hold_wait);
    logic [2:0][W-1:0] p;
    logic [2*W-1:0]    full;
    bit                abort;
    int                end_e;

    for (int i = 0; i < 3; i++) begin
      full = a[i] * b[i];
      p[i] = full[W-1:0];
    end
    abort = (stop_at <= 3) || (stop_at >= TIMEOUT);
    end_e = (stop_at >= TIMEOUT) ? TIMEOUT : stop_at + 1;

    check_outs("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_err);
    noise(1'b1);
    bus.i_load_valid = 1'b1;
    bus.i_a0 = a[0]; bus.i_a1 = a[1]; bus.i_a2 = a[2];
    bus.i_b0 = b[0]; bus.i_b1 = b[1]; bus.i_b2 = b[2];
    exp_err = 1'b0;

    for (int e = 0; e < end_e; e++) begin
      tick();
      check_outs($sformatf("E%0d", e), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq($sformatf("E%0d.multiplier", e),   bus.o_multiplier,   a[pair_of(e)]);
      check_eq($sformatf("E%0d.multiplicand", e), bus.o_multiplicand, b[pair_of(e)]);
      noise(1'b0);
      bus.i_stop = (e == stop_at);
      if (e == stop_at) begin
        bus.i_q1 = p[0]; bus.i_q2 = p[1]; bus.i_q3 = p[2];
      end
    end

    tick();
    if (!abort) exp_r = p;
    exp_err = abort;
    check_outs("clear", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, abort);
    noise(1'b1);

    if (!abort) begin
      for (int h = 0; h <= hold_wait; h++) begin
        tick();
        check_outs($sformatf("hold%0d", h), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        noise(1'b1);
        bus.i_load_valid = 1'b1;
        bus.i_res_ready  = (h == hold_wait);
      end
    end

    tick();
    bus.i_load_valid = 1'b0;
  endtask

  task automatic idle_gap();
    check_outs("gap", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_err);
    noise(1'b1);
    bus.i_load_valid = 1'b0;
    tick();
  endtask

  task automatic reset_mid_job(input logic [2:0][W-1:0] a, input logic [2:0][W-1:0] b);
    check_outs("rst_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_err);
    bus.i_load_valid = 1'b1;
    bus.i_stop = 1'b0;
    bus.i_a0 = a[0]; bus.i_a1 = a[1]; bus.i_a2 = a[2];
    bus.i_b0 = b[0]; bus.i_b1 = b[1]; bus.i_b2 = b[2];
    tick();
    bus.i_load_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    exp_r   = '0;
    exp_err = 1'b0;
    check_outs("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_mid.multiplier",   bus.o_multiplier,   '0);
    check_eq("rst_mid.multiplicand", bus.o_multiplicand, '0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0][W-1:0] ra;
    logic [2:0][W-1:0] rb;
    int                sel;
    int                stop_at;

    bus.i_load_valid = 1'b0;
    bus.i_a0 = '0; bus.i_a1 = '0; bus.i_a2 = '0;
    bus.i_b0 = '0; bus.i_b1 = '0; bus.i_b2 = '0;
    bus.i_stop = 1'b0;
    bus.i_q1 = '0; bus.i_q2 = '0; bus.i_q3 = '0;
    bus.i_res_ready = 1'b0;
    exp_r   = '0;
    exp_err = 1'b0;

    #12;
    check_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("reset.multiplier",   bus.o_multiplier,   '0);
    check_eq("reset.multiplicand", bus.o_multiplicand, '0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Nominal, truncation, backpressure
    do_job({16'd7, 16'd5, 16'd3}, {16'd6, 16'd4, 16'd2}, 4, 0);
    do_job({16'h0000, 16'hFFFF, 16'h0100}, {16'd9, 16'd2, 16'h0100}, 4, 0);
    do_job({16'd11, 16'd13, 16'd17}, {16'd19, 16'd23, 16'd29}, 4, 10);
    // Timeout, then a job that clears the error
    do_job({16'd1, 16'd2, 16'd3}, {16'd4, 16'd5, 16'd6}, NO_STOP, 0);
    do_job({16'd7, 16'd5, 16'd3}, {16'd6, 16'd4, 16'd2}, 4, 0);
    // Early stop keeps the previous results
    do_job({16'd9, 16'd9, 16'd9}, {16'd9, 16'd9, 16'd9}, 2, 0);
    // Late stop at the last legal cycle still captures
    do_job({16'd100, 16'd200, 16'd300}, {16'd3, 16'd3, 16'd3}, TIMEOUT - 1, 1);
    // Reset mid-job, then a fresh job
    reset_mid_job({16'd4, 16'd4, 16'd4}, {16'd5, 16'd5, 16'd5});
    do_job({16'd2, 16'd3, 16'd4}, {16'd5, 16'd6, 16'd7}, 4, 0);

    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < 3; i++) begin
        ra[i] = W'($urandom);
        rb[i] = W'($urandom);
      end
      sel = $urandom_range(0, 9);
      if (sel <= 1)      stop_at = $urandom_range(0, 3);
      else if (sel == 2) stop_at = NO_STOP;
      else               stop_at = $urandom_range(4, TIMEOUT - 1);
      do_job(ra, rb, stop_at, $urandom_range(0, 3));
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_gap();
    end
    idle_gap();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
